// File: rtl/aes_scan_pkg.sv
// Shared types and widths for the AES scan-chain sequencer.
package aes_scan_pkg;
  localparam int CHAIN_W_DEF = 387;
  localparam int TEXT_W      = 128;
  localparam int KEY_W       = 256;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    LOAD,
    WAIT,
    SHIFT_OUT,
    DONE
  } state_t;
endpackage

// File: rtl/aes_scan_sequencer_if.sv
// Host/core bus of the AES scan sequencer; cycles_o exists only with AES_SCAN_CYCLE_CNT_EN.
interface aes_scan_sequencer_if;
  import aes_scan_pkg::*;

  // start_i is a request sampled only while busy_o is low; done_o is a one-cycle
  // completion pulse with data_o/timeout_o valid in that same cycle.
  logic              start_i;
  logic [TEXT_W-1:0] text_i;
  logic [KEY_W-1:0]  key_i;
  logic              pt_sel_i;
  logic              key_sel_i;
  logic              ct_out_sel_i;
  logic              scan_en_o;
  logic              scan_in_o;
  logic              scan_out_i;
  logic              load_o;
  logic              trigger_i;
  logic [TEXT_W-1:0] data_o;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;
  state_t            dbg_state;
`ifdef AES_SCAN_CYCLE_CNT_EN
  logic [31:0]       cycles_o;
`endif

  modport master (
    output start_i, text_i, key_i, pt_sel_i, key_sel_i, ct_out_sel_i,
    output scan_out_i, trigger_i,
`ifdef AES_SCAN_CYCLE_CNT_EN
    input  cycles_o,
`endif
    input  scan_en_o, scan_in_o, load_o, data_o, busy_o, done_o, timeout_o, dbg_state
  );

  modport slave (
    input  start_i, text_i, key_i, pt_sel_i, key_sel_i, ct_out_sel_i,
    input  scan_out_i, trigger_i,
`ifdef AES_SCAN_CYCLE_CNT_EN
    output cycles_o,
`endif
    output scan_en_o, scan_in_o, load_o, data_o, busy_o, done_o, timeout_o, dbg_state
  );
endinterface

// File: rtl/aes_scan_shreg.sv
// Parallel-load shift register, serial in at the MSB, serial out from bit 0.
module aes_scan_shreg
  import aes_scan_pkg::*;
#(
  parameter int W     = CHAIN_W_DEF,
  parameter int CAP_W = TEXT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     pdata,
  input  logic             shift,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [CAP_W-1:0] cap
);
  logic [W-1:0] q;
  logic [W-1:0] nxt;

  assign nxt     = {ser_in, q[W-1:1]};
  assign ser_out = q[0];
  // Low bits as they will be after this cycle's shift, so the final shift can be captured directly.
  assign cap     = nxt[CAP_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= pdata;
    else if (shift) q <= nxt;
  end
endmodule

// File: rtl/aes_scan_sequencer.sv
// Scans text/key/mode into an AES core, pulses load, waits for trigger, scans result out.
// Optional AES_SCAN_CYCLE_CNT_EN adds cycles_o with the WAIT-cycle count of the last run.
module aes_scan_sequencer
  import aes_scan_pkg::*;
#(
  parameter int CHAIN_W = CHAIN_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input logic                 clk,
  input logic                 rst,
  aes_scan_sequencer_if.slave bus
);
  localparam int               CNT_W     = $clog2(CHAIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_W - 1);
  localparam logic [31:0]      WAIT_LAST = 32'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [31:0]        wait_cnt;
  logic               sh_load;
  logic               sh_shift;
  logic               sh_out;
  logic [TEXT_W-1:0]  sh_cap;
  logic [CHAIN_W-1:0] load_vec;

  assign load_vec = CHAIN_W'({bus.text_i, bus.key_i, bus.pt_sel_i, bus.key_sel_i, bus.ct_out_sel_i});
  assign sh_load  = (state == IDLE) && bus.start_i;
  assign sh_shift = (state == SHIFT_IN) || (state == SHIFT_OUT);

  aes_scan_shreg #(.W(CHAIN_W), .CAP_W(TEXT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .pdata   (load_vec),
    .shift   (sh_shift),
    .ser_in  (bus.scan_out_i),
    .ser_out (sh_out),
    .cap     (sh_cap)
  );

  assign bus.scan_in_o = (state == SHIFT_IN) && sh_out;
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      bus.scan_en_o <= 1'b0;
      bus.load_o    <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.timeout_o <= 1'b0;
      bus.data_o    <= '0;
`ifdef AES_SCAN_CYCLE_CNT_EN
      bus.cycles_o  <= '0;
`endif
    end else begin
      bus.load_o <= 1'b0;
      bus.done_o <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          state         <= SHIFT_IN;
          bit_cnt       <= '0;
          wait_cnt      <= '0;
          bus.busy_o    <= 1'b1;
          bus.scan_en_o <= 1'b1;
          bus.timeout_o <= 1'b0;
        end
        SHIFT_IN: if (bit_cnt == LAST_BIT) begin
          state         <= LOAD;
          bit_cnt       <= '0;
          bus.scan_en_o <= 1'b0;
          bus.load_o    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        LOAD: state <= WAIT;
        WAIT: if (bus.trigger_i) begin
          state         <= SHIFT_OUT;
          bus.scan_en_o <= 1'b1;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          // Timed out: skip the unload so data_o keeps the previous result.
          state         <= DONE;
          bus.timeout_o <= 1'b1;
          bus.done_o    <= 1'b1;
          wait_cnt      <= wait_cnt + 32'd1;
`ifdef AES_SCAN_CYCLE_CNT_EN
          bus.cycles_o  <= wait_cnt + 32'd1;
`endif
        end else if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + 32'd1;
        end
        SHIFT_OUT: if (bit_cnt == LAST_BIT) begin
          state         <= DONE;
          bit_cnt       <= '0;
          bus.scan_en_o <= 1'b0;
          bus.done_o    <= 1'b1;
          bus.data_o    <= sh_cap;
`ifdef AES_SCAN_CYCLE_CNT_EN
          bus.cycles_o  <= wait_cnt;
`endif
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_scan_sequencer.sv
// Directed bench for aes_scan_sequencer: FIPS-197 vector, bit order, timeout, ignored starts, reset.
`timescale 1ns/1ps
module tb_aes_scan_sequencer;
  import aes_scan_pkg::*;

  localparam int C  = 387;
  localparam int TO = 16;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT2      = 128'hcafef00d_12345678_9abcdef0_0badbeef;
  localparam logic [127:0] CT3      = 128'h80000000_00000000_00000000_00000001;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rel, load_cnt, done_cnt, en_cnt;

  aes_scan_sequencer_if a_if();
  aes_scan_sequencer_if b_if();

  aes_scan_sequencer #(.CHAIN_W(C), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(a_if));
  aes_scan_sequencer #(.CHAIN_W(C), .TIMEOUT(0))  dut_nto (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [C-1:0] obs, input logic [C-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    if (a_if.load_o)    load_cnt++;
    if (a_if.done_o)    done_cnt++;
    if (a_if.scan_en_o) en_cnt++;
  endtask

  // Plays host and core for one run on dut; lat = steps from start to done_o, or -1.
  task automatic run_op(input logic [127:0] text, input logic [255:0] key, input logic [2:0] modes,
                        input int trig_n, input bit early, input bit dbl_start, input int rst_at,
                        input logic [127:0] ct, output int lat, output logic [C-1:0] got);
    logic [C-1:0] ob;
    int j;
    ob = '0;
    ob[127:0] = ct;
    got = '0;
    lat = -1;
    rel = 0; load_cnt = 0; done_cnt = 0; en_cnt = 0;
    a_if.text_i = text;
    a_if.key_i  = key;
    {a_if.pt_sel_i, a_if.key_sel_i, a_if.ct_out_sel_i} = modes;
    a_if.trigger_i = early;
    a_if.start_i = 1'b1;
    step();
    a_if.start_i = 1'b0;
    for (int k = 0; k < C; k++) begin
      got[k] = a_if.scan_in_o;
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_if.trigger_i = 1'b0;
        return;
      end
      if (dbl_start && (k == 4 || k == 199)) a_if.start_i = 1'b1;
      step();
      a_if.start_i = 1'b0;
    end
    chk("load_pulse", a_if.load_o, 1'b1);
    chk("load_state", a_if.dbg_state, LOAD);
    chk("scan_en_low_in_load", a_if.scan_en_o, 1'b0);
    step();
    j = 0;
    while (!a_if.done_o && j < 6000) begin
      if (trig_n >= 0 && j == trig_n) a_if.trigger_i = 1'b1;
      step();
      if (a_if.trigger_i) begin
        a_if.trigger_i = 1'b0;
        break;
      end
      j++;
    end
    if (!a_if.done_o) begin
      for (int k = 0; k < C; k++) begin
        a_if.scan_out_i = ob[k];
        step();
      end
      a_if.scan_out_i = 1'b0;
    end
    for (int b = 0; b < 50 && !a_if.done_o; b++) step();
    if (a_if.done_o) lat = rel;
  endtask

  initial begin
    int lat;
    logic [C-1:0] got;
    rst = 1'b1;
    a_if.start_i = 1'b0; a_if.text_i = '0; a_if.key_i = '0;
    a_if.pt_sel_i = 1'b0; a_if.key_sel_i = 1'b0; a_if.ct_out_sel_i = 1'b0;
    a_if.scan_out_i = 1'b0; a_if.trigger_i = 1'b0;
    b_if.start_i = 1'b0; b_if.text_i = '0; b_if.key_i = '0;
    b_if.pt_sel_i = 1'b0; b_if.key_sel_i = 1'b0; b_if.ct_out_sel_i = 1'b0;
    b_if.scan_out_i = 1'b0; b_if.trigger_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", a_if.busy_o, 1'b0);
    chk("rst_done", a_if.done_o, 1'b0);
    chk("rst_load", a_if.load_o, 1'b0);
    chk("rst_scan_en", a_if.scan_en_o, 1'b0);
    chk("rst_scan_in", a_if.scan_in_o, 1'b0);
    chk("rst_timeout", a_if.timeout_o, 1'b0);
    chk("rst_data", a_if.data_o, '0);
    chk("rst_state", a_if.dbg_state, IDLE);

    // FIPS-197 AES-256 vector, core answers after 14 WAIT cycles.
    run_op(FIPS_PT, FIPS_KEY, 3'b111, 14, 1'b0, 1'b0, -1, FIPS_CT, lat, got);
    chk("fips_latency", lat, 2 * C + 17);
    chk("fips_data", a_if.data_o, FIPS_CT);
    chk("fips_timeout", a_if.timeout_o, 1'b0);
    chk("fips_busy_in_done", a_if.busy_o, 1'b1);
    chk("fips_chain_out", got, {FIPS_PT, FIPS_KEY, 3'b111});
    chk("fips_scan_en_cycles", en_cnt, 2 * C);
`ifdef AES_SCAN_CYCLE_CNT_EN
    chk("fips_cycles", a_if.cycles_o, 14);
`endif
    step();
    chk("fips_done_one_cycle", a_if.done_o, 1'b0);
    chk("fips_idle_busy", a_if.busy_o, 1'b0);

    // Bit order with zero text/key and modes 1,1,0; no trigger so the run times out.
    run_op('0, '0, 3'b110, -1, 1'b0, 1'b0, -1, CT2, lat, got);
    chk("bit_order", got, 387'd6);
    chk("to_latency", lat, C + 2 + TO);
    chk("to_flag", a_if.timeout_o, 1'b1);
    chk("to_data_kept", a_if.data_o, FIPS_CT);
    chk("to_scan_en_cycles", en_cnt, C);
    chk("to_load_count", load_cnt, 1);
    repeat (5) step();
    chk("to_flag_held", a_if.timeout_o, 1'b1);
    chk("to_idle_busy", a_if.busy_o, 1'b0);

    // Extra start pulses during SHIFT_IN must be ignored.
    run_op(128'h0123456789abcdeffedcba9876543210, {8{32'h5a5aa5a5}}, 3'b010, 5, 1'b0, 1'b1, -1,
           CT2, lat, got);
    chk("dbl_latency", lat, 2 * C + 8);
    chk("dbl_data", a_if.data_o, CT2);
    chk("dbl_timeout_cleared", a_if.timeout_o, 1'b0);
    repeat (20) step();
    chk("dbl_one_load", load_cnt, 1);
    chk("dbl_one_done", done_cnt, 1);
    chk("dbl_idle", a_if.busy_o, 1'b0);

    // Trigger held high from start: ignored until WAIT, accepted on its first cycle.
    run_op(FIPS_PT, FIPS_KEY, 3'b001, 0, 1'b1, 1'b0, -1, CT3, lat, got);
    chk("early_latency", lat, 2 * C + 3);
    chk("early_data", a_if.data_o, CT3);
    chk("early_one_load", load_cnt, 1);

    // Reset at SHIFT_IN bit 100.
    run_op(FIPS_PT, FIPS_KEY, 3'b111, 14, 1'b0, 1'b0, 100, FIPS_CT, lat, got);
    chk("mid_rst_busy", a_if.busy_o, 1'b0);
    chk("mid_rst_scan_en", a_if.scan_en_o, 1'b0);
    chk("mid_rst_scan_in", a_if.scan_in_o, 1'b0);
    chk("mid_rst_data", a_if.data_o, '0);
    chk("mid_rst_timeout", a_if.timeout_o, 1'b0);
    chk("mid_rst_state", a_if.dbg_state, IDLE);
    repeat (10) step();
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_no_load", load_cnt, 0);

    run_op(FIPS_PT, FIPS_KEY, 3'b111, 14, 1'b0, 1'b0, -1, FIPS_CT, lat, got);
    chk("fresh_latency", lat, 2 * C + 17);
    chk("fresh_data", a_if.data_o, FIPS_CT);
    step();

    // Timeout disabled: 37 WAIT cycles complete normally.
    rel = 0;
    b_if.start_i = 1'b1;
    step();
    b_if.start_i = 1'b0;
    for (int b = 0; b < 2 * C && !b_if.load_o; b++) step();
    chk("nto_load_at", rel, C + 1);
    step();
    repeat (37) step();
    b_if.trigger_i = 1'b1;
    step();
    b_if.trigger_i = 1'b0;
    for (int b = 0; b < 3 * C && !b_if.done_o; b++) step();
    chk("nto_latency", rel, 2 * C + 40);
    chk("nto_done", b_if.done_o, 1'b1);
    chk("nto_timeout", b_if.timeout_o, 1'b0);
`ifdef AES_SCAN_CYCLE_CNT_EN
    chk("nto_cycles", b_if.cycles_o, 37);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_scan_sequencer.md
AES_SCAN_SEQUENCER -- requirements
Module: aes_scan_sequencer

Interface
REQ-001 Parameter CHAIN_W, default 387: scan-chain length, ordered {text, key, pt_sel, key_sel, ct_out_sel}.
REQ-002 Parameter TIMEOUT, default 4096: maximum WAIT cycles; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  request; sampled only in IDLE.
REQ-006 text_i  in  128  plaintext.
REQ-007 key_i  in  256  key.
REQ-008 pt_sel_i, key_sel_i, ct_out_sel_i  in  1 each  core mode bits.
REQ-009 scan_en_o  out  1  high during SHIFT_IN and SHIFT_OUT.
REQ-010 scan_in_o  out  1  serial data to core chain.
REQ-011 scan_out_i  in  1  serial data from core chain.
REQ-012 load_o  out  1  one-cycle core load/start pulse.
REQ-013 trigger_i  in  1  core completion flag.
REQ-014 data_o  out  128  ciphertext, captured chain bits [127:0].
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  1  one-cycle completion pulse.
REQ-017 timeout_o  out  1  set with done_o when WAIT expired; held until next start.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT_IN, LOAD, WAIT, SHIFT_OUT, DONE.
REQ-019 IDLE & start_i: latch {text_i, key_i, pt_sel_i, key_sel_i, ct_out_sel_i} into a CHAIN_W shift register, clear timeout_o, go to SHIFT_IN.
REQ-020 SHIFT_IN: exactly CHAIN_W cycles, scan_in_o = shift register bit 0, shift right each cycle; then LOAD.
REQ-021 LOAD: load_o = 1 for one cycle; then WAIT.
REQ-022 WAIT: trigger_i sampled only here; trigger_i = 1 -> SHIFT_OUT; otherwise increment wait counter.
REQ-023 WAIT with TIMEOUT != 0 and counter == TIMEOUT-1 without trigger: set timeout_o, go to DONE, skip SHIFT_OUT, leave data_o unchanged.
REQ-024 SHIFT_OUT: exactly CHAIN_W cycles; scan_out_i enters at MSB and shifts right, so the first received bit ends at bit 0; then DONE.
REQ-025 DONE: data_o <= capture[127:0] (unless timed out), done_o = 1 for one cycle, return to IDLE.
REQ-026 Latency from start to done_o SHALL be 2*CHAIN_W + 3 + n cycles, where n = WAIT cycles before trigger.
REQ-027 start_i while busy_o = 1 SHALL be ignored, not queued.
REQ-028 trigger_i asserted in LOAD or earlier SHALL be ignored. A trigger_i still high on the first WAIT cycle SHALL be accepted.
REQ-029 The bit counter SHALL be ceil(log2(CHAIN_W+1)) wide and never wrap mid-shift.

Reset
REQ-030 rst in any state SHALL force IDLE on the next edge and clear the counters.
REQ-031 On reset, all outputs SHALL be 0, including data_o.
REQ-032 Reset mid-operation SHALL produce no done_o and no load_o pulse.

Configuration
REQ-033 Macro AES_SCAN_CYCLE_CNT_EN defined: add output cycles_o (32 bits) holding the WAIT-cycle count of the last run, updated in DONE, reset to 0.
REQ-034 Macro undefined: no cycles_o port and no counter register; all other behaviour identical.

Structure
REQ-035 Shared package aes_scan_pkg SHALL hold the FSM state enum, CHAIN_W_DEF = 387, TEXT_W = 128 and KEY_W = 256.
REQ-036 One sub-module, aes_scan_shreg, SHALL implement the parallel-load, serial-in/serial-out CHAIN_W shift register, used for both directions.

Verification
REQ-037 FIPS-197 AES-256: text 00112233445566778899aabbccddeeff, key 000102..1f, core model with trigger after 14 cycles -> data_o = 8ea2b7ca516745bfeafc49904b496089, done_o exactly 2*387+17 cycles after start.
REQ-038 Bit order: text = 0, key = 0, mode bits 1,1,0 -> scan_in_o emits 0,1,1 first, then 384 zeros; scan_en_o high exactly 387 cycles.
REQ-039 Timeout: TIMEOUT = 16, trigger_i never high -> timeout_o = 1 and done_o after 387+2+16 cycles, scan_en_o low after SHIFT_IN, data_o unchanged.
REQ-040 start_i pulsed at cycles 5 and 200 of a run -> exactly one done_o, one load_o.
REQ-041 rst at SHIFT_IN bit 100 -> all outputs 0 next cycle, no done_o; a fresh start completes correctly.
REQ-042 With AES_SCAN_CYCLE_CNT_EN, trigger after 37 WAIT cycles -> cycles_o = 37.
